// File: rtl/apb_master_pkg.sv
// Shared types and default widths for the APB requester.
//   apb_state_e : requester FSM states
//   apb_cmd_t   : command payload (write, addr, wdata)
//   apb_rsp_t   : response payload (rdata, timeout, wait_cnt)
package apb_master_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              timeout;
    logic [CNT_W-1:0]  wait_cnt;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_ctrl_wait_counter.sv
// Wait-state counter for the ACCESS phase.
//   pclk, preset_n : clock, synchronous active-low reset
//   clr            : zero the count (takes priority over inc)
//   inc            : count one wait state, saturating at all-ones
//   cnt            : registered count
//   hit_c          : cnt+1 reaches TIMEOUT_CYC (never when TIMEOUT_CYC==0)
module apb_wait_counter #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             hit_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   TO_VAL  = (CNT_W+1)'(TIMEOUT_CYC);

  logic [CNT_W:0] cnt_p1_c;

  // One extra bit so the compare never wraps at the saturation value.
  assign cnt_p1_c = {1'b0, cnt} + (CNT_W+1)'(1);
  assign hit_c    = (TIMEOUT_CYC != 0) && (cnt_p1_c == TO_VAL);

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB requester: turns a valid/ready command into one SETUP/ACCESS transfer
// and returns a single-cycle response with read data or a timeout flag.
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata : command port
//   rsp_valid/rsp_rdata/rsp_timeout/rsp_wait_cnt     : response port
//   psel/penable/pwrite/paddr/pwdata/prdata/pready   : APB requester side
// cmd_ready is decoded from the state register; every other output is a flop.
module apb_master_ctrl #(
  parameter int unsigned ADDR_W      = apb_master_pkg::ADDR_W,
  parameter int unsigned DATA_W      = apb_master_pkg::DATA_W,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = apb_master_pkg::CNT_W
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic [CNT_W-1:0]  rsp_wait_cnt,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  import apb_master_pkg::*;

  apb_state_e        state_q, state_d;
  logic              psel_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d;
  logic              rsp_valid_d, rsp_timeout_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic [CNT_W-1:0]  rsp_wait_cnt_d;
  logic              cnt_clr_c, cnt_inc_c, cnt_hit_c;
  logic [CNT_W-1:0]  cnt;

  assign cmd_ready = (state_q == IDLE);

  apb_wait_counter #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_cnt (
    .pclk     (pclk),
    .preset_n (preset_n),
    .clr      (cnt_clr_c),
    .inc      (cnt_inc_c),
    .cnt      (cnt),
    .hit_c    (cnt_hit_c)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_d        = state_q;
    psel_d         = psel;
    penable_d      = penable;
    pwrite_d       = pwrite;
    paddr_d        = paddr;
    pwdata_d       = pwdata;
    rsp_valid_d    = 1'b0;
    rsp_rdata_d    = rsp_rdata;
    rsp_timeout_d  = rsp_timeout;
    rsp_wait_cnt_d = rsp_wait_cnt;
    cnt_clr_c      = 1'b0;
    cnt_inc_c      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        cnt_clr_c = 1'b1;
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // pready is checked first so it beats a simultaneous timeout.
        if (pready) begin
          psel_d         = 1'b0;
          penable_d      = 1'b0;
          state_d        = IDLE;
          rsp_valid_d    = 1'b1;
          rsp_timeout_d  = 1'b0;
          rsp_wait_cnt_d = cnt;
          rsp_rdata_d    = pwrite ? '0 : prdata;
        end else if (cnt_hit_c) begin
          psel_d         = 1'b0;
          penable_d      = 1'b0;
          state_d        = IDLE;
          rsp_valid_d    = 1'b1;
          rsp_timeout_d  = 1'b1;
          rsp_wait_cnt_d = CNT_W'(TIMEOUT_CYC);
          rsp_rdata_d    = '0;
        end else begin
          cnt_inc_c = 1'b1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q      <= IDLE;
      psel         <= 1'b0;
      penable      <= 1'b0;
      pwrite       <= 1'b0;
      paddr        <= '0;
      pwdata       <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_timeout  <= 1'b0;
      rsp_wait_cnt <= '0;
    end else begin
      state_q      <= state_d;
      psel         <= psel_d;
      penable      <= penable_d;
      pwrite       <= pwrite_d;
      paddr        <= paddr_d;
      pwdata       <= pwdata_d;
      rsp_valid    <= rsp_valid_d;
      rsp_rdata    <= rsp_rdata_d;
      rsp_timeout  <= rsp_timeout_d;
      rsp_wait_cnt <= rsp_wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: table of transfers with expected responses,
// an APB completer model with programmable wait states, a response
// scoreboard, plus sequences for mid-transfer reset and back-to-back writes.
module tb_apb_master_ctrl;
  import apb_master_pkg::*;

  localparam int unsigned TO = 16;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [7:0]  rsp_wait_cnt;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready;

  apb_master_ctrl #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO), .CNT_W(8)
  ) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .rsp_wait_cnt(rsp_wait_cnt),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Completer model: 16-word store, index 4 is a fixed read-only pattern.
  int          acc_cnt = 0;
  int          wait_target = 0;
  logic        stuck = 1'b0;
  logic [31:0] mem [16];
  int          wr_count = 0;

  function automatic logic [3:0] midx(input logic [31:0] a);
    return a[15:12] ^ a[5:2];
  endfunction

  assign pready = psel && penable && !stuck && (acc_cnt == wait_target);
  assign prdata = (midx(paddr) == 4'd4) ? 32'h1234_5678 : mem[midx(paddr)];

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (psel && penable && pready && pwrite) begin
      mem[midx(paddr)] <= pwdata;
      wr_count         <= wr_count + 1;
    end
  end

  // Scoreboard: expected responses queued at command issue.
  apb_rsp_t exp_q[$];
  int       rsp_times[$];

  always @(negedge pclk) begin : mon
    apb_rsp_t e;
    if (rsp_valid) begin
      rsp_times.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_payload", {rsp_rdata, rsp_timeout, rsp_wait_cnt}, e);
      end
    end
  end

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        stuck;
    logic [31:0] exp_rdata;
    logic        exp_to;
    logic [7:0]  exp_wc;
  } vec_t;

  task automatic do_xfer(input vec_t v);
    int       n;
    int       pen;
    logic     bad;
    apb_rsp_t e;
    @(negedge pclk);
    wait_target = v.waits;
    stuck       = v.stuck;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    e.rdata    = v.exp_rdata;
    e.timeout  = v.exp_to;
    e.wait_cnt = v.exp_wc;
    exp_q.push_back(e);
    @(posedge pclk);
    #1;
    cmd_valid = 1'b0;
    cmd_write = ~v.write;
    cmd_addr  = 32'hFFFF_FFF0;
    n = 0; pen = 0; bad = 1'b0;
    do begin
      @(negedge pclk);
      n++;
      if (penable) pen++;
      if (psel && (paddr !== v.addr || pwrite !== v.write ||
                   (v.write && pwdata !== v.wdata))) bad = 1'b1;
    end while (!rsp_valid && n < 60);
    chk("latency", n, v.stuck ? TO + 2 : v.waits + 3);
    chk("penable_cycles", pen, v.stuck ? TO : v.waits + 1);
    chk("addr_stable", bad, 0);
    chk("bus_idle_on_rsp", {psel, penable, cmd_ready}, 3'b001);
    @(negedge pclk);
    chk("rsp_hold", {rsp_valid, rsp_rdata, rsp_timeout, rsp_wait_cnt}, {1'b0, e});
  endtask

  vec_t vecs[8];

  initial begin : wdog
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   n0, base, nr, n;
    vec_t v;

    vecs[0] = '{1'b1, 32'h0000_A000, 32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
    vecs[1] = '{1'b0, 32'h0000_A000, 32'h0,         0, 1'b0, 32'hDEAD_BEEF, 1'b0, 8'd0};
    vecs[2] = '{1'b0, 32'h0000_0010, 32'h0,         3, 1'b0, 32'h1234_5678, 1'b0, 8'd3};
    vecs[3] = '{1'b0, 32'h0000_0020, 32'h0,         0, 1'b1, 32'h0000_0000, 1'b1, 8'd16};
    vecs[4] = '{1'b1, 32'h0000_0004, 32'h0000_55AA, 2, 1'b0, 32'h0000_0000, 1'b0, 8'd2};
    vecs[5] = '{1'b0, 32'h0000_0004, 32'h0,         1, 1'b0, 32'h0000_55AA, 1'b0, 8'd1};
    vecs[6] = '{1'b1, 32'h0000_002C, 32'hCAFE_F00D, 0, 1'b1, 32'h0000_0000, 1'b1, 8'd16};
    vecs[7] = '{1'b0, 32'h0000_0010, 32'h0,         5, 1'b0, 32'h1234_5678, 1'b0, 8'd5};

    preset_n  = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("reset_ctrl", {psel, penable, pwrite, rsp_valid, rsp_timeout, cmd_ready}, 6'b000001);
    chk("reset_addr", paddr, 0);
    chk("reset_wdata", pwdata, 0);
    chk("reset_rsp", {rsp_rdata, rsp_wait_cnt}, 0);
    preset_n = 1'b1;

    foreach (vecs[i]) do_xfer(vecs[i]);

    // Reset asserted for one edge during ACCESS of a write.
    @(negedge pclk);
    wait_target = 5;
    stuck       = 1'b0;
    cmd_valid   = 1'b1;
    cmd_write   = 1'b1;
    cmd_addr    = 32'h0000_0030;
    cmd_wdata   = 32'hBAD0_BAD0;
    @(posedge pclk);
    #1;
    cmd_valid = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    chk("in_access", {psel, penable}, 2'b11);
    n0 = rsp_times.size();
    preset_n = 1'b0;
    @(negedge pclk);
    chk("reset_abort", {psel, penable, cmd_ready, rsp_valid}, 4'b0010);
    preset_n = 1'b1;
    repeat (8) @(negedge pclk);
    chk("no_rsp_after_reset", rsp_times.size(), n0);
    v = '{1'b0, 32'h0000_A000, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 8'd0};
    do_xfer(v);

    // Back-to-back writes with cmd_valid held high.
    wait_target = 0;
    stuck       = 1'b0;
    base        = rsp_times.size();
    @(negedge pclk);
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'(i * 4);
      cmd_wdata = 32'hB0B0_0000 + 32'(i);
      nr = 0;
      while (!cmd_ready && nr < 20) begin
        @(negedge pclk);
        nr++;
      end
      chk("b2b_gap", nr, (i == 0) ? 0 : 3);
      exp_q.push_back('{rdata: 32'h0, timeout: 1'b0, wait_cnt: 8'd0});
      @(posedge pclk);
      #1;
    end
    cmd_valid = 1'b0;
    n = 0;
    while ((rsp_times.size() - base) < 4 && n < 40) begin
      @(negedge pclk);
      n++;
    end
    repeat (4) @(negedge pclk);
    chk("b2b_count", rsp_times.size() - base, 4);
    if (rsp_times.size() - base >= 4) begin
      for (int i = 1; i < 4; i++)
        chk("b2b_spacing", rsp_times[base+i] - rsp_times[base+i-1], 3);
    end
    for (int i = 0; i < 4; i++)
      chk("b2b_mem", mem[i], 32'hB0B0_0000 + 32'(i));
    chk("write_commits", wr_count, 6);
    chk("mem_A000", mem[10], 32'hDEAD_BEEF);
    chk("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
